// File: rtl/branch_resolve_unit_if.sv
// Bundle of execute-stage inputs, branch flags and the fetch redirect/flush
// outputs of the branch resolve unit.
//   slave  : used by branch_resolve_unit (consumes ex_*/br_*/redirect_ready,
//            drives redirect_valid/redirect_pc/flush/busy and result pulses)
//   master : used by the surrounding pipeline (or a testbench)
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_stall;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [2:0]      ex_funct3;
    logic            br_eq;
    logic            br_lt;
    logic            br_ltu;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            busy;
    logic            branch_taken;
    logic            mispredict;
    logic            illegal_branch;

    modport slave (
        input  ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_funct3, br_eq, br_lt, br_ltu, ex_pc, ex_target,
               ex_pred_taken, redirect_ready,
        output redirect_valid, redirect_pc, flush, busy,
               branch_taken, mispredict, illegal_branch
    );

    modport master (
        output ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_funct3, br_eq, br_lt, br_ltu, ex_pc, ex_target,
               ex_pred_taken, redirect_ready,
        input  redirect_valid, redirect_pc, flush, busy,
               branch_taken, mispredict, illegal_branch
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: combines execute-stage compare flags with funct3 and
// the fetch prediction, reports taken/mispredict/illegal pulses, and on a
// mispredict holds a redirect request to fetch followed by a timed flush.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave modport) : execute inputs, redirect handshake, flush/busy,
//                         result pulses (see branch_resolve_unit_if)
// Optional feature (define BRANCH_STATS_EN):
//   stat_clear          : in, synchronous clear of both counters
//   stat_branches       : out[32], resolved (legal) control transfers
//   stat_mispredicts    : out[32], mispredicts; both saturate
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bus
`ifdef BRANCH_STATS_EN
    ,
    input  logic                  stat_clear,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [XLEN-1:0]   redirect_pc_r, redirect_pc_n;
    logic              redirect_valid_r, flush_r, busy_r;
    logic              taken_pulse_r, mispredict_pulse_r, illegal_pulse_r;

    logic              resolve_s;
    logic              taken_s;
    logic              illegal_s;
    logic              mispredict_s;
    logic [XLEN-1:0]   jump_tgt_s;
    logic [XLEN-1:0]   corr_pc_s;

    // Branch condition from funct3 and the execute-stage flags.
    function automatic logic branch_cond_f(input logic [2:0] f3, input logic eq,
                                           input logic lt, input logic ltu);
        logic r;
        case (f3)
            3'b000:  r = eq;
            3'b001:  r = ~eq;
            3'b100:  r = lt;
            3'b101:  r = ~lt;
            3'b110:  r = ltu;
            3'b111:  r = ~ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Reserved branch encodings 010 and 011.
    function automatic logic illegal_f3_f(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // Decode the resolving instruction: direction, target and mispredict.
    always_comb begin
        resolve_s  = bus.ex_valid & ~bus.ex_stall & (state_r == ST_IDLE) &
                     (bus.ex_is_branch | bus.ex_is_jal | bus.ex_is_jalr);
        taken_s    = 1'b0;
        illegal_s  = 1'b0;
        jump_tgt_s = bus.ex_target;
        // jalr > jal > branch when several type bits are set
        if (bus.ex_is_jalr) begin
            taken_s    = 1'b1;
            jump_tgt_s = {bus.ex_target[XLEN-1:1], 1'b0};
        end else if (bus.ex_is_jal) begin
            taken_s    = 1'b1;
        end else begin
            illegal_s  = illegal_f3_f(bus.ex_funct3);
            taken_s    = ~illegal_s &
                         branch_cond_f(bus.ex_funct3, bus.br_eq, bus.br_lt, bus.br_ltu);
        end
        corr_pc_s    = taken_s ? jump_tgt_s : (bus.ex_pc + XLEN'(4));
        mispredict_s = ~illegal_s & (taken_s != bus.ex_pred_taken);
    end

    // Next-state logic for the redirect/flush sequence.
    always_comb begin
        state_n       = state_r;
        cnt_n         = cnt_r;
        redirect_pc_n = redirect_pc_r;
        case (state_r)
            ST_IDLE: begin
                if (resolve_s && mispredict_s) begin
                    state_n       = ST_REDIRECT;
                    redirect_pc_n = corr_pc_s;
                end else begin
                    state_n       = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                // redirect_pc is held until fetch takes it
                if (bus.redirect_ready) begin
                    if (FLUSH_CYCLES > 0) begin
                        state_n = ST_FLUSH;
                        cnt_n   = CNT_W'(FLUSH_CYCLES);
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_n = ST_REDIRECT;
                end
            end
            ST_FLUSH: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = {CNT_W{1'b0}};
                end else begin
                    cnt_n   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r            <= ST_IDLE;
            cnt_r              <= {CNT_W{1'b0}};
            redirect_pc_r      <= {XLEN{1'b0}};
            redirect_valid_r   <= 1'b0;
            flush_r            <= 1'b0;
            busy_r             <= 1'b0;
            taken_pulse_r      <= 1'b0;
            mispredict_pulse_r <= 1'b0;
            illegal_pulse_r    <= 1'b0;
        end else begin
            state_r            <= state_n;
            cnt_r              <= cnt_n;
            redirect_pc_r      <= redirect_pc_n;
            redirect_valid_r   <= (state_n == ST_REDIRECT);
            flush_r            <= (state_n != ST_IDLE);
            busy_r             <= (state_n != ST_IDLE);
            taken_pulse_r      <= resolve_s & taken_s;
            mispredict_pulse_r <= resolve_s & mispredict_s;
            illegal_pulse_r    <= resolve_s & illegal_s;
        end
    end

    assign bus.redirect_valid = redirect_valid_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.flush          = flush_r;
    assign bus.busy           = busy_r;
    assign bus.branch_taken   = taken_pulse_r;
    assign bus.mispredict     = mispredict_pulse_r;
    assign bus.illegal_branch = illegal_pulse_r;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispredicts_r;

    // Saturating resolve/mispredict counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else begin
            if (resolve_s && !illegal_s && (stat_branches_r != 32'hFFFF_FFFF)) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end else begin
                stat_branches_r <= stat_branches_r;
            end
            if (resolve_s && mispredict_s && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end else begin
                stat_mispredicts_r <= stat_mispredicts_r;
            end
        end
    end

    assign stat_branches    = stat_branches_r;
    assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int FLUSH = 2;

    logic clk;
    logic reset;
    logic [31:0] op_a, op_b;

    int errors;
    int checks;

    // expected-value model state
    bit          m_pending;
    int          m_flush_left;
    logic [31:0] m_pc;
    logic        m_taken, m_mis, m_ill;

    branch_resolve_unit_if #(.XLEN(XLEN)) bif ();

`ifdef BRANCH_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_branches, stat_mispredicts;
    logic [31:0] m_sb, m_sm;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
`ifdef BRANCH_STATS_EN
        ,
        .stat_clear       (stat_clear),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // flags derived from the source operands, as the ALU would produce them
    assign bif.br_eq  = (op_a == op_b);
    assign bif.br_lt  = ($signed(op_a) < $signed(op_b));
    assign bif.br_ltu = (op_a < op_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs currently driven.
    task automatic model_step();
        bit          res, tk, ill;
        logic [31:0] tgt;
        m_taken = 1'b0; m_mis = 1'b0; m_ill = 1'b0;
        res = 1'b0; tk = 1'b0; ill = 1'b0; tgt = bif.ex_target;
        if (reset) begin
            m_pending = 1'b0; m_flush_left = 0; m_pc = 32'd0;
`ifdef BRANCH_STATS_EN
            m_sb = 32'd0; m_sm = 32'd0;
`endif
            return;
        end
        if (m_pending || m_flush_left > 0) begin
            if (m_pending) begin
                if (bif.redirect_ready) begin
                    m_pending = 1'b0;
                    m_flush_left = FLUSH;
                end
            end else begin
                m_flush_left--;
            end
        end else if (bif.ex_valid && !bif.ex_stall &&
                     (bif.ex_is_branch || bif.ex_is_jal || bif.ex_is_jalr)) begin
            res = 1'b1;
            if (bif.ex_is_jalr) begin
                tk = 1'b1; tgt = bif.ex_target & 32'hFFFF_FFFE;
            end else if (bif.ex_is_jal) begin
                tk = 1'b1;
            end else begin
                case (bif.ex_funct3)
                    3'd0: tk = (op_a == op_b);
                    3'd1: tk = (op_a != op_b);
                    3'd4: tk = ($signed(op_a) <  $signed(op_b));
                    3'd5: tk = ($signed(op_a) >= $signed(op_b));
                    3'd6: tk = (op_a <  op_b);
                    3'd7: tk = (op_a >= op_b);
                    default: ill = 1'b1;
                endcase
            end
            m_ill = ill;
            if (!ill) begin
                m_taken = tk;
                m_mis   = (tk != bif.ex_pred_taken);
                if (m_mis) begin
                    m_pending = 1'b1;
                    m_pc = tk ? tgt : bif.ex_pc + 32'd4;
                end
            end
        end
`ifdef BRANCH_STATS_EN
        if (stat_clear) begin
            m_sb = 32'd0; m_sm = 32'd0;
        end else begin
            if (res && !ill && m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 32'd1;
            if (m_mis && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 32'd1;
        end
`endif
    endtask

    task automatic cyc();
        logic act;
        model_step();
        @(posedge clk);
        #1;
        act = m_pending || (m_flush_left > 0);
        check("redirect_valid", 32'(bif.redirect_valid), 32'(m_pending));
        check("redirect_pc",    bif.redirect_pc,          m_pc);
        check("flush",          32'(bif.flush),           32'(act));
        check("busy",           32'(bif.busy),            32'(act));
        check("branch_taken",   32'(bif.branch_taken),    32'(m_taken));
        check("mispredict",     32'(bif.mispredict),      32'(m_mis));
        check("illegal_branch", 32'(bif.illegal_branch),  32'(m_ill));
`ifdef BRANCH_STATS_EN
        check("stat_branches",    stat_branches,    m_sb);
        check("stat_mispredicts", stat_mispredicts, m_sm);
`endif
    endtask

    // kind: {jalr, jal, branch}
    task automatic drive(input logic v, input logic [2:0] kind, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic rdy);
        bif.ex_valid      = v;
        bif.ex_stall      = 1'b0;
        bif.ex_is_branch  = kind[0];
        bif.ex_is_jal     = kind[1];
        bif.ex_is_jalr    = kind[2];
        bif.ex_funct3     = f3;
        op_a              = a;
        op_b              = b;
        bif.ex_pc         = pc;
        bif.ex_target     = tgt;
        bif.ex_pred_taken = pred;
        bif.redirect_ready = rdy;
    endtask

    task automatic idle(input logic rdy, input int n);
        drive(1'b0, 3'b000, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rdy);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        errors = 0; checks = 0;
        m_pending = 1'b0; m_flush_left = 0; m_pc = 32'd0;
`ifdef BRANCH_STATS_EN
        stat_clear = 1'b0; m_sb = 32'd0; m_sm = 32'd0;
`endif
        reset = 1'b1;
        idle(1'b0, 2);
        reset = 1'b0;
        idle(1'b0, 1);

        // BEQ taken, predicted not taken, fetch ready at once
        drive(1'b1, 3'b001, 3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0, 1'b1);
        cyc();
        check("beq_pc", bif.redirect_pc, 32'h140);
        check("beq_mis", 32'(bif.mispredict), 32'd1);
        idle(1'b1, 4);
        check("beq_busy_after", 32'(bif.busy), 32'd0);

        // BNE not taken, predicted taken, fetch stalls 3 cycles
        drive(1'b1, 3'b001, 3'd1, 32'd7, 32'd7, 32'h200, 32'h280, 1'b1, 1'b0);
        cyc();
        idle(1'b0, 3);
        check("bne_pc_held", bif.redirect_pc, 32'h204);
        check("bne_valid_held", 32'(bif.redirect_valid), 32'd1);
        idle(1'b1, 4);

        // BLTU taken, correctly predicted
        drive(1'b1, 3'b001, 3'd6, 32'd1, 32'hFFFF_0000, 32'h300, 32'h360, 1'b1, 1'b1);
        cyc();
        check("bltu_busy", 32'(bif.busy), 32'd0);
        idle(1'b0, 1);

        // reserved funct3
        drive(1'b1, 3'b001, 3'd2, 32'd1, 32'd2, 32'h400, 32'h440, 1'b1, 1'b1);
        cyc();
        check("illegal_pulse", 32'(bif.illegal_branch), 32'd1);
        idle(1'b0, 1);

        // JALR with odd target, reset mid-flush
        drive(1'b1, 3'b100, 3'd0, 32'd0, 32'd0, 32'h500, 32'h301, 1'b0, 1'b1);
        cyc();
        check("jalr_pc", bif.redirect_pc, 32'h300);
        idle(1'b1, 1);
        reset = 1'b1;
        idle(1'b0, 1);
        check("reset_flush", 32'(bif.flush), 32'd0);
        check("reset_pc", bif.redirect_pc, 32'd0);
        reset = 1'b0;
        idle(1'b0, 1);

        // PC wrap: BGE taken (predicted), then BLT not taken (mispredicted)
        drive(1'b1, 3'b001, 3'd5, 32'd9, 32'd3, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 3'b001, 3'd4, 32'd9, 32'd3, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b1);
        cyc();
        check("wrap_pc", bif.redirect_pc, 32'h0000_0000);
`ifdef BRANCH_STATS_EN
        check("wrap_stat_br", stat_branches, 32'd2);
        check("wrap_stat_mis", stat_mispredicts, 32'd1);
`endif
        idle(1'b1, 4);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = $urandom;
            drive(($urandom_range(0, 9) < 8), 3'($urandom), 3'($urandom), a,
                  ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
                  32'($urandom) & 32'hFFFF_FFFC, 32'($urandom),
                  1'($urandom), 1'($urandom));
            bif.ex_stall = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 49) == 0);
`ifdef BRANCH_STATS_EN
            stat_clear = ($urandom_range(0, 19) == 0);
`endif
            cyc();
        end
        reset = 1'b0;
        idle(1'b1, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
